// File: rtl/cpu_player.sv
// cpu_player: computer-controlled tug-of-war opponent.
// Produces pseudo-random "button" press waveforms gated by a 4-bit difficulty.
// Optional press counter enabled by defining CPU_PLAYER_COUNT_EN.
module cpu_player #(
  parameter int LFSR_WIDTH  = 10,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] difficulty,
  output logic       button
`ifdef CPU_PLAYER_COUNT_EN
  ,
  output logic [7:0] presses
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [LFSR_WIDTH-1:0]   q;
  logic                    hit;
  logic                    launch;

  // The press decision looks at the top nibble of the LFSR before it shifts
  assign hit    = (q[LFSR_WIDTH-1 -: 4] < difficulty);
  assign launch = (state == IDLE) && enable && hit;

  // Free-running XNOR LFSR (taps 10,7); all-ones lock-up is unreachable from zero
  always_ff @(posedge Clock) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= {q[LFSR_WIDTH-2:0], ~(q[LFSR_WIDTH-1] ^ q[LFSR_WIDTH-4])};
    end
  end

  // State, hold/gap counter and the registered button level
  always_ff @(posedge Clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      button <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      button <= (state_nxt == PRESS);
    end
  end

  // Next-state logic: hold the key, force a release gap, then look for a new hit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef CPU_PLAYER_COUNT_EN
  // Count every press that starts; wraps naturally at 8 bits
  always_ff @(posedge Clock) begin
    if (reset) begin
      presses <= 8'd0;
    end else if (launch) begin
      presses <= presses + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_player.sv
// tb_cpu_player: randomized and directed checks of cpu_player against a
// timeline model of the press waveform. Handles CPU_PLAYER_COUNT_EN builds.
module tb_cpu_player;

  localparam int HOLD = 3;
  localparam int GAP  = 2;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] difficulty = 4'd0;
  logic       button;
`ifdef CPU_PLAYER_COUNT_EN
  logic [7:0] presses;
`endif

  int checks = 0;
  int failures = 0;

  // Free-running 10-unit clock
  always #5 Clock = ~Clock;

  cpu_player #(
    .LFSR_WIDTH (10),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .Clock     (Clock),
    .reset     (reset),
    .enable    (enable),
    .difficulty(difficulty),
    .button    (button)
`ifdef CPU_PLAYER_COUNT_EN
    ,
    .presses   (presses)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] d, input int n);
    reset = r;
    enable = e;
    difficulty = d;
    repeat (n) @(negedge Clock);
  endtask

  // Timeline model: m_busy counts cycles left in the current press+gap window
  int m_q = 0;
  int m_busy = 0;
  int m_presses = 0;
  bit m_valid = 1'b0;

  // Advance the model at each rising edge using the stable inputs
  always @(posedge Clock) begin
    if (reset) begin
      m_q = 0;
      m_busy = 0;
      m_presses = 0;
      m_valid = 1'b1;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
      end else if (enable && ((m_q >> 6) < int'(difficulty))) begin
        m_busy = HOLD + GAP;
        m_presses = (m_presses + 1) % 256;
      end
      m_q = ((m_q << 1) | ((((m_q >> 9) ^ (m_q >> 6)) & 1) ^ 1)) & 1023;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge Clock) begin
    if (m_valid) begin
      checkOutput("button", 32'(button), 32'(m_busy > GAP));
      checkOutput("lfsr_q", 32'(dut.q), 32'(m_q));
`ifdef CPU_PLAYER_COUNT_EN
      checkOutput("presses", 32'(presses), 32'(m_presses));
`endif
    end
  end

  // Downstream press handler: one-cycle pulse per rising edge of button
  logic btn_d = 1'b0;
  int   pulse_count = 0;
  always @(posedge Clock) btn_d <= button;
  always @(negedge Clock) if (button && !btn_d) pulse_count++;

  // Leave reset with difficulty 15 and confirm the first two presses' timing
  task automatic runFirstPress();
    logic [6:0] got;
    got = '0;
    reset = 1'b0;
    enable = 1'b1;
    difficulty = 4'd15;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock);
      got[6-i] = button;
      if (i == 5) checkOutput("lfsr_after_6", 32'(dut.q), 32'h03F);
    end
    checkOutput("first_press_pattern", 32'(got), 32'b1110001);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int highs;
    int distinct;
    int rises;
    logic prev;
    bit seen [1024];

    // Reset state
    applyStimulus(1'b1, 1'b0, 4'd0, 2);
    checkOutput("reset_button", 32'(button), 32'd0);
`ifdef CPU_PLAYER_COUNT_EN
    checkOutput("reset_presses", 32'(presses), 32'd0);
`endif
    runFirstPress();

    // Difficulty zero never presses
    applyStimulus(1'b1, 1'b1, 4'd0, 2);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clock);
      if (button) highs++;
    end
    checkOutput("diff0_highs", 32'(highs), 32'd0);

    // Enable dropped on the second PRESS cycle
    applyStimulus(1'b1, 1'b0, 4'd15, 2);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (button) highs++;
    end
    checkOutput("disable_tail_highs", 32'(highs), 32'd1);
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clock);
      if (button) highs++;
    end
    checkOutput("disable_no_press", 32'(highs), 32'd0);

    // Reset asserted on the second PRESS cycle
    applyStimulus(1'b1, 1'b0, 4'd15, 2);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
    checkOutput("reset_mid_press", 32'(button), 32'd0);
    @(negedge Clock);
    runFirstPress();

    // LFSR period and visit-once
    applyStimulus(1'b1, 1'b0, 4'd0, 2);
    reset = 1'b0;
    distinct = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      if (!seen[int'(dut.q)]) distinct++;
      seen[int'(dut.q)] = 1'b1;
      @(negedge Clock);
    end
    checkOutput("lfsr_distinct", 32'(distinct), 32'd1023);
    checkOutput("lfsr_lockup_seen", 32'(seen[1023]), 32'd0);
    checkOutput("lfsr_wrap", 32'(dut.q), 32'd0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) difficulty = 4'($urandom_range(0, 15));
      @(negedge Clock);
    end

    // 300 presses at top difficulty; counter wraps to 44
    applyStimulus(1'b1, 1'b1, 4'd15, 2);
    pulse_count = 0;
    reset = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 5000 && rises < 300; i++) begin
      @(negedge Clock);
      if (button && !prev) rises++;
      prev = button;
    end
    checkOutput("rises_300_timeout", 32'(rises), 32'd300);
    @(negedge Clock);
    checkOutput("handler_pulses", 32'(pulse_count), 32'd300);
`ifdef CPU_PLAYER_COUNT_EN
    checkOutput("presses_300", 32'(presses), 32'd44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
